// File: rtl/nios_fprint_timestamp_sequencer_if.sv
// Halfword register bus of the 16-bit Avalon-MM interval/timestamp timer.
// The sequencer is the master; the timer (or a bench model of it) is the slave.
interface nios_fprint_timestamp_sequencer_if;
    logic [3:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;

    modport master (
        output tmr_address,
        output tmr_chipselect,
        output tmr_write_n,
        output tmr_writedata,
        input  tmr_readdata
    );

    modport slave (
        input  tmr_address,
        input  tmr_chipselect,
        input  tmr_write_n,
        input  tmr_writedata,
        output tmr_readdata
    );
endinterface

// File: rtl/nios_fprint_timestamp_sequencer.sv
// Shares the interval timer between NREQ snapshot requesters and one config requester.
// Define TSSEQ_ELAPSED_EN to keep per-requester previous snapshots and report elapsed ticks.
module nios_fprint_timestamp_sequencer #(
    parameter int unsigned NREQ = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] snap_req,
    output logic [NREQ-1:0] snap_ack,
    output logic [63:0]     snap_value,
    output logic [63:0]     snap_delta,
    input  logic            cfg_req,
    input  logic [63:0]     cfg_period,
    input  logic            cfg_continuous,
    input  logic            cfg_irq_en,
    output logic            cfg_ack,
    output logic            busy,
    nios_fprint_timestamp_sequencer_if.master tmr
);

    typedef enum logic [2:0] {
        StIdle,
        StCfgWr,
        StSnapWr,
        StSnapRd,
        StSnapLast
    } state_e;

    state_e          state_q;
    logic [1:0]      idx_q;
    logic            ctrl_q;
    logic [2:0]      rr_ptr_q;
    logic [NREQ-1:0] gnt_oh_q;
    logic [63:0]     cfg_period_q;
    logic            cfg_continuous_q;
    logic            cfg_irq_en_q;
    logic [47:0]     hw_q;

    logic            cfg_eff;
    logic [NREQ-1:0] req_rot;
    logic            gnt_found;
    logic [NREQ-1:0] gnt_oh;
    logic [2:0]      gnt_ptr_nxt;
    logic [1:0]      idx_inc;
    logic [63:0]     snap_cur;

    assign busy     = (state_q != StIdle);
    assign idx_inc  = idx_q + 2'd1;
    assign snap_cur = {tmr.tmr_readdata, hw_q};
    // Requests being acked this cycle are masked so a held level is not re-granted.
    assign cfg_eff  = cfg_req & ~cfg_ack;

    // Round-robin: rotate so the pointer lands on bit 0, take the lowest set bit.
    always_comb begin
        req_rot     = NREQ'({snap_req & ~snap_ack, snap_req & ~snap_ack} >> rr_ptr_q);
        gnt_found   = 1'b0;
        gnt_oh      = '0;
        gnt_ptr_nxt = rr_ptr_q;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (!gnt_found && req_rot[k]) begin
                gnt_found   = 1'b1;
                gnt_oh      = NREQ'(1) << ((int'(rr_ptr_q) + k) % int'(NREQ));
                gnt_ptr_nxt = 3'((int'(rr_ptr_q) + k + 1) % int'(NREQ));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q            <= StIdle;
            idx_q              <= 2'd0;
            ctrl_q             <= 1'b0;
            rr_ptr_q           <= 3'd0;
            gnt_oh_q           <= '0;
            cfg_period_q       <= '0;
            cfg_continuous_q   <= 1'b0;
            cfg_irq_en_q       <= 1'b0;
            hw_q               <= '0;
            snap_ack           <= '0;
            snap_value         <= '0;
            cfg_ack            <= 1'b0;
            tmr.tmr_chipselect <= 1'b0;
            tmr.tmr_write_n    <= 1'b1;
            tmr.tmr_address    <= 4'd0;
            tmr.tmr_writedata  <= 16'd0;
        end else begin
            snap_ack           <= '0;
            cfg_ack            <= 1'b0;
            tmr.tmr_chipselect <= 1'b0;
            tmr.tmr_write_n    <= 1'b1;
            tmr.tmr_address    <= 4'd0;
            tmr.tmr_writedata  <= 16'd0;
            unique case (state_q)
                StIdle: begin
                    if (cfg_eff) begin
                        state_q            <= StCfgWr;
                        idx_q              <= 2'd0;
                        ctrl_q             <= 1'b0;
                        cfg_period_q       <= cfg_period;
                        cfg_continuous_q   <= cfg_continuous;
                        cfg_irq_en_q       <= cfg_irq_en;
                        tmr.tmr_chipselect <= 1'b1;
                        tmr.tmr_write_n    <= 1'b0;
                        tmr.tmr_address    <= 4'd2;
                        tmr.tmr_writedata  <= cfg_period[15:0];
                    end else if (gnt_found) begin
                        state_q            <= StSnapWr;
                        gnt_oh_q           <= gnt_oh;
                        rr_ptr_q           <= gnt_ptr_nxt;
                        tmr.tmr_chipselect <= 1'b1;
                        tmr.tmr_write_n    <= 1'b0;
                        tmr.tmr_address    <= 4'd6;
                    end
                end
                StCfgWr: begin
                    if (ctrl_q) begin
                        state_q <= StIdle;
                        cfg_ack <= 1'b1;
                    end else if (idx_q == 2'd3) begin
                        // Control register: stop=0, start=1.
                        ctrl_q             <= 1'b1;
                        tmr.tmr_chipselect <= 1'b1;
                        tmr.tmr_write_n    <= 1'b0;
                        tmr.tmr_address    <= 4'd1;
                        tmr.tmr_writedata  <= {12'b0, 1'b0, 1'b1, cfg_continuous_q, cfg_irq_en_q};
                    end else begin
                        idx_q              <= idx_inc;
                        tmr.tmr_chipselect <= 1'b1;
                        tmr.tmr_write_n    <= 1'b0;
                        tmr.tmr_address    <= 4'd3 + {2'b00, idx_q};
                        tmr.tmr_writedata  <= cfg_period_q[16*idx_inc +: 16];
                    end
                end
                StSnapWr: begin
                    state_q            <= StSnapRd;
                    idx_q              <= 2'd0;
                    tmr.tmr_chipselect <= 1'b1;
                    tmr.tmr_address    <= 4'd6;
                end
                StSnapRd: begin
                    // Read data lags the address by one cycle.
                    unique case (idx_q)
                        2'd1:    hw_q[15:0]  <= tmr.tmr_readdata;
                        2'd2:    hw_q[31:16] <= tmr.tmr_readdata;
                        2'd3:    hw_q[47:32] <= tmr.tmr_readdata;
                        default: ;
                    endcase
                    if (idx_q == 2'd3) begin
                        state_q <= StSnapLast;
                    end else begin
                        idx_q              <= idx_inc;
                        tmr.tmr_chipselect <= 1'b1;
                        tmr.tmr_address    <= 4'd7 + {2'b00, idx_q};
                    end
                end
                StSnapLast: begin
                    state_q    <= StIdle;
                    snap_value <= snap_cur;
                    snap_ack   <= gnt_oh_q;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef TSSEQ_ELAPSED_EN
    logic [63:0]     prev_q [NREQ];
    logic [NREQ-1:0] prev_valid_q;
    logic [63:0]     prev_sel;
    logic            prev_ok;

    always_comb begin
        prev_sel = '0;
        prev_ok  = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt_oh_q[i]) begin
                prev_sel = prev_q[i];
                prev_ok  = prev_valid_q[i];
            end
        end
    end

    // The timer counts down, so elapsed ticks are previous minus current.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            snap_delta   <= '0;
            prev_valid_q <= '0;
        end else if (state_q == StSnapLast) begin
            snap_delta <= prev_ok ? (prev_sel - snap_cur) : 64'd0;
            for (int i = 0; i < int'(NREQ); i++) begin
                if (gnt_oh_q[i]) begin
                    prev_q[i]       <= snap_cur;
                    prev_valid_q[i] <= 1'b1;
                end
            end
        end
    end
`else
    assign snap_delta = '0;
`endif

endmodule

// File: tb/tb_nios_fprint_timestamp_sequencer.sv
// Scoreboard bench: stimulus queues expected acks/writes, a negedge monitor pops and compares.
module tb_nios_fprint_timestamp_sequencer;
    localparam int unsigned NREQ = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NREQ-1:0] snap_req;
    logic [NREQ-1:0] snap_ack;
    logic [63:0]     snap_value;
    logic [63:0]     snap_delta;
    logic            cfg_req;
    logic [63:0]     cfg_period;
    logic            cfg_continuous;
    logic            cfg_irq_en;
    logic            cfg_ack;
    logic            busy;

    nios_fprint_timestamp_sequencer_if tmr ();

    nios_fprint_timestamp_sequencer #(.NREQ(NREQ)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .snap_req       (snap_req),
        .snap_ack       (snap_ack),
        .snap_value     (snap_value),
        .snap_delta     (snap_delta),
        .cfg_req        (cfg_req),
        .cfg_period     (cfg_period),
        .cfg_continuous (cfg_continuous),
        .cfg_irq_en     (cfg_irq_en),
        .cfg_ack        (cfg_ack),
        .busy           (busy),
        .tmr            (tmr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Timer model: write to addr 6 latches the counter; reads of 6..9 return it a cycle later.
    logic [63:0] cnt = '0;
    logic [63:0] snap_reg = '0;
    logic [15:0] rd_q = '0;
    assign tmr.tmr_readdata = rd_q;
    always @(posedge clk) begin
        if (tmr.tmr_chipselect && !tmr.tmr_write_n && tmr.tmr_address == 4'd6) snap_reg <= cnt;
        if (tmr.tmr_chipselect && tmr.tmr_write_n) begin
            case (tmr.tmr_address)
                4'd6:    rd_q <= snap_reg[15:0];
                4'd7:    rd_q <= snap_reg[31:16];
                4'd8:    rd_q <= snap_reg[47:32];
                4'd9:    rd_q <= snap_reg[63:48];
                default: rd_q <= 16'h0000;
            endcase
        end
    end

    typedef struct {
        int          id;
        logic [63:0] value;
        logic [63:0] delta;
        int          cyc;
    } snap_exp_t;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_exp_t;

    snap_exp_t snap_q[$];
    wr_exp_t   wr_q[$];
    int        cfg_ack_q[$];
    int        vectors = 0;
    int        miscompares = 0;
    int        pend[NREQ];
    logic      cfg_pend;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name, input string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    function automatic logic [63:0] ed(input logic [63:0] d);
`ifdef TSSEQ_ELAPSED_EN
        return d;
`else
        return (d & 64'd0);
`endif
    endfunction

    task automatic exp_snap(input int id, input logic [63:0] v, input logic [63:0] d, input int c);
        snap_exp_t e;
        e.id = id; e.value = v; e.delta = ed(d); e.cyc = c;
        snap_q.push_back(e);
    endtask

    task automatic exp_wr(input logic [3:0] a, input logic [15:0] d);
        wr_exp_t w;
        w.addr = a; w.data = d;
        wr_q.push_back(w);
    endtask

    snap_exp_t mon_s;
    wr_exp_t   mon_w;
    int        mon_c;
    always @(negedge clk) begin
        if (snap_ack != '0) begin
            if (snap_q.size() == 0) begin
                flag_fail("snap_ack_unexpected", $sformatf("ack=0x%0h with nothing pending", snap_ack));
            end else begin
                mon_s = snap_q.pop_front();
                check64("snap_ack_who", 64'(snap_ack), 64'd1 << mon_s.id);
                check64("snap_value", snap_value, mon_s.value);
                check64("snap_delta", snap_delta, mon_s.delta);
                check64("snap_ack_cycle", 64'(cyc), 64'(mon_s.cyc));
            end
        end
        if (cfg_ack) begin
            if (cfg_ack_q.size() == 0) begin
                flag_fail("cfg_ack_unexpected", "cfg_ack with nothing pending");
            end else begin
                mon_c = cfg_ack_q.pop_front();
                check64("cfg_ack_cycle", 64'(cyc), 64'(mon_c));
            end
        end
        if (tmr.tmr_chipselect && !tmr.tmr_write_n) begin
            if (tmr.tmr_address == 4'd6) begin
                check64("snap_strobe_data", 64'(tmr.tmr_writedata), 64'd0);
            end else if (wr_q.size() == 0) begin
                flag_fail("write_unexpected", $sformatf("addr=%0d data=0x%0h",
                          tmr.tmr_address, tmr.tmr_writedata));
            end else begin
                mon_w = wr_q.pop_front();
                check64("cfg_write_addr", 64'(tmr.tmr_address), 64'(mon_w.addr));
                check64("cfg_write_data", 64'(tmr.tmr_writedata), 64'(mon_w.data));
            end
        end
    end

    // One cycle; requesters drop their level on their ack.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < int'(NREQ); i++) begin
            if (snap_ack[i] && pend[i] > 0) begin
                pend[i]--;
                if (pend[i] == 0) snap_req[i] = 1'b0;
            end
        end
        if (cfg_ack && cfg_pend) begin
            cfg_pend = 1'b0;
            cfg_req  = 1'b0;
        end
    endtask

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        while ((busy || cfg_req || snap_req != '0 || snap_q.size() != 0 ||
                cfg_ack_q.size() != 0 || wr_q.size() != 0) && n < limit) begin
            step();
            n++;
        end
        if (n >= limit) flag_fail(name, "timed out waiting for transactions");
        step();
    endtask

    int t0;
    initial begin
        reset_n        = 1'b0;
        snap_req       = '0;
        cfg_req        = 1'b0;
        cfg_pend       = 1'b0;
        cfg_period     = '0;
        cfg_continuous = 1'b0;
        cfg_irq_en     = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) pend[i] = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        step();

        check64("rst_snap_ack", 64'(snap_ack), 64'd0);
        check64("rst_cfg_ack", 64'(cfg_ack), 64'd0);
        check64("rst_busy", 64'(busy), 64'd0);
        check64("rst_snap_value", snap_value, 64'd0);
        check64("rst_snap_delta", snap_delta, 64'd0);
        check64("rst_cs", 64'(tmr.tmr_chipselect), 64'd0);
        check64("rst_write_n", 64'(tmr.tmr_write_n), 64'd1);
        check64("rst_addr", 64'(tmr.tmr_address), 64'd0);
        check64("rst_wdata", 64'(tmr.tmr_writedata), 64'd0);

        // Config: period 100000, continuous, irq enabled.
        cfg_period = 64'h0000_0000_0001_86A0; cfg_continuous = 1'b1; cfg_irq_en = 1'b1;
        exp_wr(4'd2, 16'h86A0); exp_wr(4'd3, 16'h0001); exp_wr(4'd4, 16'h0000);
        exp_wr(4'd5, 16'h0000); exp_wr(4'd1, 16'h0007);
        cfg_ack_q.push_back(cyc + 6);
        cfg_req = 1'b1; cfg_pend = 1'b1;
        step();
        cfg_period = '1; cfg_continuous = 1'b0; cfg_irq_en = 1'b0;
        wait_done("cfg_basic", 40);

        // Single snapshot from requester 0.
        cnt = 64'h1234_5678_9ABC_DEF0;
        exp_snap(0, cnt, 64'd0, cyc + 7);
        pend[0] = 1; snap_req[0] = 1'b1;
        wait_done("snap_single", 40);

        // All three held: pointer is at 1 now, so service is 1,2,0,1,2,0.
        cnt = 64'h1111_2222_3333_4444;
        t0 = cyc;
        exp_snap(1, cnt, 64'd0, t0 + 7);
        exp_snap(2, cnt, 64'd0, t0 + 14);
        exp_snap(0, cnt, 64'h0123_3456_6789_9AAC, t0 + 21);
        exp_snap(1, cnt, 64'd0, t0 + 28);
        exp_snap(2, cnt, 64'd0, t0 + 35);
        exp_snap(0, cnt, 64'd0, t0 + 42);
        for (int i = 0; i < int'(NREQ); i++) pend[i] = 2;
        snap_req = '1;
        wait_done("snap_rr", 100);

        // Config arrives mid-snapshot: snapshot finishes, config next, waiting snapshot last.
        cnt = 64'h0000_0000_0000_1000;
        t0 = cyc;
        exp_snap(2, cnt, 64'h1111_2222_3333_3444, t0 + 7);
        pend[2] = 1; snap_req[2] = 1'b1;
        repeat (3) step();
        cfg_period = 64'hFEDC_BA98_7654_3210; cfg_continuous = 1'b0; cfg_irq_en = 1'b1;
        exp_wr(4'd2, 16'h3210); exp_wr(4'd3, 16'h7654); exp_wr(4'd4, 16'hBA98);
        exp_wr(4'd5, 16'hFEDC); exp_wr(4'd1, 16'h0005);
        cfg_ack_q.push_back(t0 + 13);
        exp_snap(0, cnt, 64'h1111_2222_3333_3444, t0 + 20);
        cfg_req = 1'b1; cfg_pend = 1'b1;
        pend[0] = 1; snap_req[0] = 1'b1;
        wait_done("cfg_vs_snap", 60);

        // Reset during the idx=2 read: no ack may follow.
        pend[1] = 1; snap_req[1] = 1'b1;
        repeat (4) step();
        check64("mid_busy", 64'(busy), 64'd1);
        check64("mid_rd_cs", 64'(tmr.tmr_chipselect), 64'd1);
        check64("mid_rd_addr", 64'(tmr.tmr_address), 64'd8);
        reset_n = 1'b0;
        step();
        check64("mrst_busy", 64'(busy), 64'd0);
        check64("mrst_cs", 64'(tmr.tmr_chipselect), 64'd0);
        check64("mrst_write_n", 64'(tmr.tmr_write_n), 64'd1);
        check64("mrst_addr", 64'(tmr.tmr_address), 64'd0);
        check64("mrst_snap_ack", 64'(snap_ack), 64'd0);
        check64("mrst_snap_value", snap_value, 64'd0);
        check64("mrst_snap_delta", snap_delta, 64'd0);
        pend[1] = 0; snap_req = '0;
        step();
        reset_n = 1'b1;
        repeat (10) step();

        // Elapsed: requester 0 at 1000 then 400 after reset.
        cnt = 64'd1000;
        exp_snap(0, cnt, 64'd0, cyc + 7);
        pend[0] = 1; snap_req[0] = 1'b1;
        wait_done("elapsed_first", 40);
        cnt = 64'd400;
        exp_snap(0, cnt, 64'd600, cyc + 7);
        pend[0] = 1; snap_req[0] = 1'b1;
        wait_done("elapsed_second", 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
